// File: rtl/instr_mem_responder.sv
// instr_mem_responder: memory side of the fetch req/gnt/rvalid protocol.
// Grants after WAIT_STATES held-req cycles and answers each grant
// RVALID_LATENCY cycles later, in order, from a preloadable word array.
// Ports: clk, rst_n (synchronous, active low)
//   instr_req_i, instr_addr_i            fetch request in
//   instr_gnt_o                          grant (combinational)
//   instr_rvalid_o, instr_rdata_o,
//   instr_err_o                          registered response out
//   load_we_i, load_addr_i, load_wdata_i preload write port
// Option: define INSTR_MEM_RANDOM_STALL_EN for LFSR-driven grant stalls.
module instr_mem_responder #(
   parameter int unsigned           WORD_WIDTH     = 32,
   parameter int unsigned           DEPTH          = 1024,
   parameter logic [WORD_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int unsigned           WAIT_STATES    = 0,
   parameter int unsigned           RVALID_LATENCY = 1,
   parameter logic [WORD_WIDTH-1:0] NOP_INSTR      = 32'h0000_0013,
   localparam int unsigned          AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_req_i,
   input  logic [WORD_WIDTH-1:0] instr_addr_i,
   output logic                  instr_gnt_o,
   output logic                  instr_rvalid_o,
   output logic [WORD_WIDTH-1:0] instr_rdata_o,
   output logic                  instr_err_o,
   input  logic                  load_we_i,
   input  logic [AW-1:0]         load_addr_i,
   input  logic [WORD_WIDTH-1:0] load_wdata_i
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_GRANT
   } state_t;

   localparam logic [3:0] LP_CNT_INIT =
      (WAIT_STATES > 1) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t                r_state;
   state_t                w_state_nx;
   logic [3:0]            r_cnt;
   logic [3:0]            w_cnt_nx;
   logic                  w_gnt;
   logic                  w_stall;

   logic [RVALID_LATENCY-1:0] r_pv;
   logic                  w_fin_v;
   logic [WORD_WIDTH-1:0] w_fin_a;
   logic [WORD_WIDTH-1:0] w_off;
   logic [AW-1:0]         w_idx;
   logic                  w_err;
   logic [WORD_WIDTH-1:0] w_rd;

   logic [WORD_WIDTH-1:0] r_mem [DEPTH];
   logic [WORD_WIDTH-1:0] r_rdata;
   logic                  r_err;

`ifdef INSTR_MEM_RANDOM_STALL_EN
   logic [15:0] r_lfsr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lfsr <= 16'hACE1;
      end else begin
         r_lfsr <= {r_lfsr[14:0],
                    r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      end
   end

   assign w_stall = r_lfsr[0];
`else
   assign w_stall = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   // WAIT exits once the count reaches zero, so the grant lands in the
   // (WAIT_STATES+1)th consecutive request cycle; WAIT_STATES=1 skips WAIT.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_gnt      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (instr_req_i && !w_stall) begin
               if (WAIT_STATES == 0) begin
                  w_gnt = 1'b1;
               end else if (WAIT_STATES == 1) begin
                  w_state_nx = S_GRANT;
               end else begin
                  w_state_nx = S_WAIT;
                  w_cnt_nx   = LP_CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (!instr_req_i) begin
               w_state_nx = S_IDLE;
               w_cnt_nx   = '0;
            end else if (r_cnt <= 4'd1) begin
               w_state_nx = S_GRANT;
               w_cnt_nx   = '0;
            end else begin
               w_cnt_nx = r_cnt - 4'd1;
            end
         end
         S_GRANT: begin
            if (!instr_req_i) begin
               w_state_nx = S_IDLE;
            end else if (!w_stall) begin
               w_gnt      = 1'b1;
               w_state_nx = S_IDLE;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
         end
      endcase
   end

   // Valid bits shift one stage per cycle; the last bit is rvalid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pv <= '0;
      end else begin
         r_pv[0] <= w_gnt;
         for (int k = 1; k < RVALID_LATENCY; k++) begin
            r_pv[k] <= r_pv[k-1];
         end
      end
   end

   // The entry about to enter the final stage is the one read from the
   // array; with latency 1 that is the grant itself.
   generate
      if (RVALID_LATENCY > 1) begin : g_pipe
         logic [WORD_WIDTH-1:0] r_pa [RVALID_LATENCY-1];

         always_ff @(posedge clk) begin
            r_pa[0] <= instr_addr_i;
            for (int k = 1; k < RVALID_LATENCY - 1; k++) begin
               r_pa[k] <= r_pa[k-1];
            end
         end

         assign w_fin_v = r_pv[RVALID_LATENCY-2];
         assign w_fin_a = r_pa[RVALID_LATENCY-2];
      end else begin : g_direct
         assign w_fin_v = w_gnt;
         assign w_fin_a = instr_addr_i;
      end
   endgenerate

   assign w_off = (w_fin_a - BASE_ADDR) >> 2;
   assign w_idx = w_off[AW-1:0];
   assign w_err = (w_fin_a[1:0] != 2'b00) ||
                  (w_fin_a < BASE_ADDR) ||
                  (w_off >= WORD_WIDTH'(DEPTH));

   // Write-first: a preload to the word being read wins.
   assign w_rd = (load_we_i && (load_addr_i == w_idx)) ?
                 load_wdata_i : r_mem[w_idx];

   always_ff @(posedge clk) begin
      if (load_we_i) begin
         r_mem[load_addr_i] <= load_wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (w_fin_v) begin
         r_err   <= w_err;
         r_rdata <= w_err ? NOP_INSTR : w_rd;
      end
   end

   assign instr_gnt_o    = w_gnt;
   assign instr_rvalid_o = r_pv[RVALID_LATENCY-1];
   assign instr_rdata_o  = r_rdata;
   assign instr_err_o    = r_err;

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: directed and randomized checks of
// instr_mem_responder in three configurations sharing one preload port.
module tb_instr_mem_responder;

   localparam int          DEP = 64;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] B2  = 32'h0000_0100;

   typedef struct packed {
      int          due;
      logic [31:0] a;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        req    [3];
   logic [31:0] addr   [3];
   logic        gnt    [3];
   logic        rvalid [3];
   logic [31:0] rdata  [3];
   logic        err    [3];
   logic        ld_we;
   logic [5:0]  ld_a;
   logic [31:0] ld_d;

   logic [31:0] mdl [DEP];
   int          now;
   int          n_cmp;
   int          n_bad;

   instr_mem_responder #(
      .DEPTH(DEP), .BASE_ADDR(32'h0),
      .WAIT_STATES(0), .RVALID_LATENCY(1)
   ) u0 (
      .clk(clk), .rst_n(rst_n),
      .instr_req_i(req[0]), .instr_addr_i(addr[0]),
      .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]),
      .instr_rdata_o(rdata[0]), .instr_err_o(err[0]),
      .load_we_i(ld_we), .load_addr_i(ld_a), .load_wdata_i(ld_d)
   );

   instr_mem_responder #(
      .DEPTH(DEP), .BASE_ADDR(32'h0),
      .WAIT_STATES(2), .RVALID_LATENCY(1)
   ) u1 (
      .clk(clk), .rst_n(rst_n),
      .instr_req_i(req[1]), .instr_addr_i(addr[1]),
      .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]),
      .instr_rdata_o(rdata[1]), .instr_err_o(err[1]),
      .load_we_i(ld_we), .load_addr_i(ld_a), .load_wdata_i(ld_d)
   );

   instr_mem_responder #(
      .DEPTH(DEP), .BASE_ADDR(B2),
      .WAIT_STATES(0), .RVALID_LATENCY(3)
   ) u2 (
      .clk(clk), .rst_n(rst_n),
      .instr_req_i(req[2]), .instr_addr_i(addr[2]),
      .instr_gnt_o(gnt[2]), .instr_rvalid_o(rvalid[2]),
      .instr_rdata_o(rdata[2]), .instr_err_o(err[2]),
      .load_we_i(ld_we), .load_addr_i(ld_a), .load_wdata_i(ld_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", now);
      $fatal(1, "watchdog");
   end

`ifdef INSTR_MEM_RANDOM_STALL_EN
   logic [15:0] tb_lfsr;
   always @(posedge clk) begin
      if (!rst_n) tb_lfsr <= 16'hACE1;
      else tb_lfsr <= {tb_lfsr[14:0],
                       tb_lfsr[15] ^ tb_lfsr[13] ^ tb_lfsr[12] ^ tb_lfsr[10]};
   end
`endif

   function automatic int ws_of(input int k);
      return (k == 1) ? 2 : 0;
   endfunction

   function automatic int lat_of(input int k);
      return (k == 2) ? 3 : 1;
   endfunction

   function automatic logic [31:0] base_of(input int k);
      return (k == 2) ? B2 : 32'h0;
   endfunction

   // Expected {err, rdata} for a read of byte address a on instance k.
   function automatic logic [32:0] exp_rsp(input int k, input logic [31:0] a);
      logic [31:0] b;
      logic [31:0] w;
      b = base_of(k);
      w = (a - b) >> 2;
      if (a[1:0] != 2'b00 || a < b || w >= DEP) return {1'b1, NOP};
      return {1'b0, mdl[w]};
   endfunction

   // One cycle: commit last cycle's preload to the model, drive new inputs
   // at the falling edge, then settle before the caller samples.
   task automatic cyc(input int k, input logic rq, input logic [31:0] ad,
                      input logic we = 1'b0, input logic [5:0] la = '0,
                      input logic [31:0] wd = '0);
      @(negedge clk);
      now++;
      if (ld_we) mdl[ld_a] = ld_d;
      for (int j = 0; j < 3; j++) begin
         req[j]  = 1'b0;
         addr[j] = '0;
      end
      req[k]  = rq;
      addr[k] = ad;
      ld_we   = we;
      ld_a    = la;
      ld_d    = wd;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) cyc(0, 1'b0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (gnt[k] !== 1'b0 || rvalid[k] !== 1'b0 ||
             rdata[k] !== 32'h0 || err[k] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outs inst=%0d got g=%b v=%b d=%h e=%b want 0",
                     k, gnt[k], rvalid[k], rdata[k], err[k]);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_preload();
      for (int i = 0; i < DEP; i++) begin
         cyc(0, 1'b0, 32'h0, 1'b1, 6'(i), $urandom);
      end
      cyc(0, 1'b0, 32'h0);
   endtask

   task automatic test_seq_fetch();
      logic [31:0] w [4];
      w[0] = 32'h0050_0093;
      w[1] = 32'h0010_0113;
      w[2] = 32'h0020_81B3;
      w[3] = 32'h0000_006F;
      for (int i = 0; i < 4; i++) cyc(0, 1'b0, 32'h0, 1'b1, 6'(i), w[i]);
      for (int c = 0; c < 5; c++) begin
         cyc(0, c < 4, 32'(4 * c));
         if (c < 4) begin
            n_cmp++;
            if (gnt[0] !== 1'b1) begin
               n_bad++;
               $display("FAIL seq_gnt c=%0d got=%b want=1", c, gnt[0]);
            end
         end
         n_cmp++;
         if (c == 0) begin
            if (rvalid[0] !== 1'b0) begin
               n_bad++;
               $display("FAIL seq_rvalid0 got=%b want=0", rvalid[0]);
            end
         end else if (rvalid[0] !== 1'b1 || rdata[0] !== w[c-1] ||
                      err[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL seq_rsp c=%0d got v=%b d=%h e=%b want v=1 d=%h e=0",
                     c, rvalid[0], rdata[0], err[0], w[c-1]);
         end
      end
   endtask

   task automatic test_wait_states();
      logic [0:9] p_rq;
      logic [0:9] p_g;
      logic [0:9] p_v;
      p_rq = 10'b1110_1011_10;
      p_g  = 10'b0010_0000_10;
      p_v  = 10'b0001_0000_01;
      for (int i = 0; i < 10; i++) begin
         cyc(1, p_rq[i], 32'h10);
         n_cmp++;
         if (gnt[1] !== p_g[i] || rvalid[1] !== p_v[i]) begin
            n_bad++;
            $display("FAIL ws_timing i=%0d got g=%b v=%b want g=%b v=%b",
                     i, gnt[1], rvalid[1], p_g[i], p_v[i]);
         end
         if (p_v[i]) begin
            n_cmp++;
            if (rdata[1] !== mdl[4] || err[1] !== 1'b0) begin
               n_bad++;
               $display("FAIL ws_data i=%0d got d=%h e=%b want d=%h e=0",
                        i, rdata[1], err[1], mdl[4]);
            end
         end
      end
   endtask

   task automatic test_errors();
      cyc(0, 1'b1, 32'h6);
      cyc(0, 1'b1, 32'(DEP * 4));
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (rvalid[0] !== 1'b1 || err[0] !== 1'b1 || rdata[0] !== NOP) begin
            n_bad++;
            $display("FAIL err_rsp i=%0d got v=%b e=%b d=%h want v=1 e=1 d=%h",
                     i, rvalid[0], err[0], rdata[0], NOP);
         end
         cyc(0, 1'b0, 32'h0);
      end
      n_cmp++;
      if (rvalid[0] !== 1'b0 || err[0] !== 1'b1 || rdata[0] !== NOP) begin
         n_bad++;
         $display("FAIL err_hold got v=%b e=%b d=%h want v=0 e=1 d=%h",
                  rvalid[0], err[0], rdata[0], NOP);
      end
   endtask

   task automatic test_collision();
      cyc(0, 1'b0, 32'h0, 1'b1, 6'd5, 32'h1111_1111);
      cyc(0, 1'b1, 32'h14, 1'b1, 6'd5, 32'hDEAD_BEEF);
      cyc(0, 1'b0, 32'h0);
      n_cmp++;
      if (rvalid[0] !== 1'b1 || rdata[0] !== 32'hDEAD_BEEF || err[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL collision got v=%b d=%h e=%b want v=1 d=deadbeef e=0",
                  rvalid[0], rdata[0], err[0]);
      end
   endtask

   task automatic test_reset_midflight();
      for (int i = 0; i < 3; i++) begin
         cyc(2, 1'b1, B2 + 32'(4 * i));
         n_cmp++;
         if (gnt[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmf_gnt i=%0d got=%b want=1", i, gnt[2]);
         end
      end
      cyc(2, 1'b0, 32'h0);
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(2, 1'b0, 32'h0);
         n_cmp++;
         if (rvalid[2] !== 1'b0 || gnt[2] !== 1'b0 ||
             rdata[2] !== 32'h0 || err[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmf_outs i=%0d got v=%b g=%b d=%h e=%b want 0",
                     i, rvalid[2], gnt[2], rdata[2], err[2]);
         end
         if (i == 1) rst_n = 1'b1;
      end
   endtask

   // seq=0: random req/addr/preload traffic for n cycles.
   // seq=1: req held, sequential addresses, until n grants.
   task automatic test_random(input int k, input int n, input bit seq);
      exp_t        sb [$];
      exp_t        e;
      logic [32:0] r;
      logic [31:0] last_d;
      logic        last_e;
      bit          have_last;
      int          ngr;
      int          limit;
      int          run;
      logic        eg;
      logic [31:0] b;
      have_last = 0;
      ngr       = 0;
      run       = 0;
      b         = base_of(k);
      limit     = seq ? 40 * n : n + 8;
      for (int i = 0; i < limit; i++) begin
         logic        rq;
         logic [31:0] a;
         int          sel;
         if (seq && ngr >= n && sb.size() == 0) break;
         rq  = seq ? (ngr < n) : (i < n && $urandom_range(0, 9) < 7);
         sel = $urandom_range(0, 9);
         if (seq) a = b + 32'(4 * (ngr % DEP));
         else if (sel == 0) a = b + 32'(4 * $urandom_range(0, DEP - 1) + $urandom_range(1, 3));
         else if (sel == 1 || (sel == 2 && b == 0)) a = b + 32'(4 * (DEP + $urandom_range(0, 100)));
         else if (sel == 2) a = 32'($urandom_range(0, int'(b) - 1));
         else a = b + 32'(4 * $urandom_range(0, DEP - 1));
         cyc(k, rq, a, $urandom_range(0, 3) == 0,
             6'($urandom_range(0, DEP - 1)), $urandom);
`ifdef INSTR_MEM_RANDOM_STALL_EN
         eg = 1'b0;
         if (tb_lfsr[0]) begin
            n_cmp++;
            if (gnt[k] !== 1'b0) begin
               n_bad++;
               $display("FAIL stall_gnt inst=%0d cyc=%0d got=%b want=0",
                        k, now, gnt[k]);
            end
         end
`else
         eg = rq && (run == ws_of(k));
         run = (rq && !eg) ? run + 1 : 0;
         n_cmp++;
         if (gnt[k] !== eg) begin
            n_bad++;
            $display("FAIL rnd_gnt inst=%0d cyc=%0d got=%b want=%b",
                     k, now, gnt[k], eg);
         end
`endif
         if (rvalid[k] === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL rnd_extra inst=%0d cyc=%0d got rvalid=1 want 0",
                        k, now);
            end else begin
               e = sb.pop_front();
               r = exp_rsp(k, e.a);
               if (e.due != now || rdata[k] !== r[31:0] || err[k] !== r[32]) begin
                  n_bad++;
                  $display("FAIL rnd_rsp inst=%0d cyc=%0d a=%h got d=%h e=%b want d=%h e=%b due=%0d",
                           k, now, e.a, rdata[k], err[k], r[31:0], r[32], e.due);
               end
               last_d    = r[31:0];
               last_e    = r[32];
               have_last = 1;
            end
         end else begin
            if (have_last) begin
               n_cmp++;
               if (rdata[k] !== last_d || err[k] !== last_e) begin
                  n_bad++;
                  $display("FAIL rnd_hold inst=%0d cyc=%0d got d=%h e=%b want d=%h e=%b",
                           k, now, rdata[k], err[k], last_d, last_e);
               end
            end
            if (sb.size() > 0 && sb[0].due <= now) begin
               n_cmp++;
               n_bad++;
               e = sb.pop_front();
               $display("FAIL rnd_missing inst=%0d cyc=%0d got rvalid=0 want 1 a=%h",
                        k, now, e.a);
            end
         end
         if (gnt[k] === 1'b1) begin
            sb.push_back('{due: now + lat_of(k), a: a});
            ngr++;
         end
      end
      n_cmp++;
      if (sb.size() != 0 || (seq && ngr != n)) begin
         n_bad++;
         $display("FAIL rnd_drain inst=%0d got pending=%0d grants=%0d want pending=0 grants=%0d",
                  k, sb.size(), ngr, seq ? n : ngr);
      end
   endtask

   initial begin
      now   = 0;
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      ld_we = 1'b0;
      ld_a  = '0;
      ld_d  = '0;
      for (int j = 0; j < 3; j++) begin
         req[j]  = 1'b0;
         addr[j] = '0;
      end
      test_reset();
      test_preload();
`ifndef INSTR_MEM_RANDOM_STALL_EN
      test_seq_fetch();
      test_wait_states();
      test_errors();
      test_collision();
      test_reset_midflight();
`endif
      test_random(0, 300, 1'b0);
      test_random(1, 300, 1'b0);
      test_random(2, 300, 1'b0);
`ifdef INSTR_MEM_RANDOM_STALL_EN
      test_random(1, 200, 1'b1);
      test_random(2, 200, 1'b1);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
